// File: rtl/wb_write_queue.sv
// wb_write_queue: write-back FIFO feeding the register file write port, with pending-write detection.
// Define WBQ_BYPASS_EN to forward the youngest pending value to the read ports.
module wb_write_queue #(
   parameter int DEPTH = 4,
   parameter int NREG  = 16,
   parameter int DW    = 16,
   localparam int AW   = $clog2(NREG),
   localparam int PW   = $clog2(DEPTH),
   localparam int CW   = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wb_valid,
   output logic          wb_ready,
   input  logic [AW-1:0] wb_reg,
   input  logic [DW-1:0] wb_data,
   input  logic          rf_busy,
   output logic [NREG-1:0] WriteReg,
   output logic [DW-1:0] D,
   input  logic [AW-1:0] rd_reg1,
   input  logic [AW-1:0] rd_reg2,
   input  logic [DW-1:0] rf_data1,
   input  logic [DW-1:0] rf_data2,
   output logic [DW-1:0] rd_data1,
   output logic [DW-1:0] rd_data2,
   output logic          pending1,
   output logic          pending2,
   output logic [CW-1:0] count
);
   logic [AW-1:0]   r_qreg  [DEPTH];
   logic [DW-1:0]   r_qdata [DEPTH];
   logic [PW-1:0]   r_head, r_tail;
   logic [CW-1:0]   r_count;
   logic [NREG-1:0] r_we;
   logic [DW-1:0]   r_d;
   logic            w_push, w_pop;
   logic [AW-1:0]   w_rreg [2];
   assign wb_ready = !rst && (r_count < CW'(DEPTH));
   // R0 writes complete the handshake but are dropped here
   assign w_push   = wb_valid && wb_ready && (wb_reg != '0);
   assign w_pop    = (r_count != '0) && !rf_busy;
   assign WriteReg = r_we;
   assign D        = r_d;
   assign count    = r_count;
   assign w_rreg[0] = rd_reg1;
   assign w_rreg[1] = rd_reg2;
   always_ff @(posedge clk) begin
      if (rst) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
         r_we    <= '0;
         r_d     <= '0;
      end else begin
         if (w_push) begin
            r_qreg[r_tail]  <= wb_reg;
            r_qdata[r_tail] <= wb_data;
            r_tail          <= r_tail + 1'b1;
         end
         if (w_pop) begin
            r_head <= r_head + 1'b1;
            r_we   <= NREG'(1) << r_qreg[r_head];
            r_d    <= r_qdata[r_head];
         end else begin
            r_we   <= '0;
         end
         r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
   end
   for (genvar k = 0; k < 2; k++) begin : g_port
      logic          w_pend;
`ifdef WBQ_BYPASS_EN
      logic [DW-1:0] w_fwd;
`endif
      // Scan oldest to newest so the youngest match wins; in-flight is older than any queued entry
      always_comb begin
         w_pend = r_we[w_rreg[k]];
`ifdef WBQ_BYPASS_EN
         w_fwd  = r_we[w_rreg[k]] ? r_d : ((k == 0) ? rf_data1 : rf_data2);
`endif
         for (int i = 0; i < DEPTH; i++) begin
            if ((CW'(i) < r_count) && (r_qreg[r_head + PW'(i)] == w_rreg[k])) begin
               w_pend = 1'b1;
`ifdef WBQ_BYPASS_EN
               w_fwd  = r_qdata[r_head + PW'(i)];
`endif
            end
         end
         if (w_rreg[k] == '0) w_pend = 1'b0;
      end
   end
   assign pending1 = g_port[0].w_pend;
   assign pending2 = g_port[1].w_pend;
`ifdef WBQ_BYPASS_EN
   assign rd_data1 = g_port[0].w_fwd;
   assign rd_data2 = g_port[1].w_fwd;
`else
   assign rd_data1 = rf_data1;
   assign rd_data2 = rf_data2;
`endif
endmodule

// File: tb/tb_wb_write_queue.sv
// tb_wb_write_queue: directed tests for wb_write_queue with a small register-file model on the write port.
module tb_wb_write_queue;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        wb_valid = 1'b0;
   logic        wb_ready;
   logic [3:0]  wb_reg = '0;
   logic [15:0] wb_data = '0;
   logic        rf_busy = 1'b0;
   logic [15:0] WriteReg, D;
   logic [3:0]  rd_reg1 = '0, rd_reg2 = '0;
   logic [15:0] rf_data1, rf_data2, rd_data1, rd_data2;
   logic        pending1, pending2;
   logic [2:0]  count;
   logic [15:0] regs [16];
   logic [15:0] m_we = '0, m_d = '0;
   logic        rf2_ovr = 1'b0;
   logic [15:0] rf2_val = '0;
   logic [15:0] exp;
   logic [15:0] seen;
   int          errors = 0;
   int          checks = 0;

   always #5 clk = ~clk;

   wb_write_queue dut (
      .clk(clk), .rst(rst), .wb_valid(wb_valid), .wb_ready(wb_ready),
      .wb_reg(wb_reg), .wb_data(wb_data), .rf_busy(rf_busy),
      .WriteReg(WriteReg), .D(D), .rd_reg1(rd_reg1), .rd_reg2(rd_reg2),
      .rf_data1(rf_data1), .rf_data2(rf_data2), .rd_data1(rd_data1), .rd_data2(rd_data2),
      .pending1(pending1), .pending2(pending2), .count(count)
   );

   // Register file model: commits the write enable seen during the cycle at the next rising edge
   always @(negedge clk) begin
      m_we = WriteReg;
      m_d  = D;
   end
   always @(posedge clk)
      for (int i = 0; i < 16; i++)
         if (m_we[i]) regs[i] <= m_d;
   assign rf_data1 = regs[rd_reg1];
   assign rf_data2 = rf2_ovr ? rf2_val : regs[rd_reg2];

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      tick();
      tick();
      checks++; if (WriteReg !== 16'h0000) begin errors++; $display("FAIL reset_we got %h exp %h", WriteReg, 16'h0000); end
      checks++; if (D !== 16'h0000) begin errors++; $display("FAIL reset_d got %h exp %h", D, 16'h0000); end
      checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
      checks++; if (wb_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_hi got %b exp 0", wb_ready); end
      checks++; if (pending1 !== 1'b0 || pending2 !== 1'b0) begin errors++; $display("FAIL reset_pending got %b%b exp 00", pending1, pending2); end
      rst = 1'b0;
      #1;
      checks++; if (wb_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_lo got %b exp 1", wb_ready); end
   endtask

   task automatic test_single;
      wb_valid = 1'b1; wb_reg = 4'd3; wb_data = 16'h1234; rd_reg1 = 4'd3;
      tick();
      wb_valid = 1'b0;
      #1;
      checks++; if (count !== 3'd1) begin errors++; $display("FAIL single_count1 got %0d exp 1", count); end
      checks++; if (WriteReg !== 16'h0000) begin errors++; $display("FAIL single_we_early got %h exp 0000", WriteReg); end
      checks++; if (pending1 !== 1'b1) begin errors++; $display("FAIL single_pend_q got %b exp 1", pending1); end
      tick();
      checks++; if (WriteReg !== 16'h0008) begin errors++; $display("FAIL single_we got %h exp 0008", WriteReg); end
      checks++; if (D !== 16'h1234) begin errors++; $display("FAIL single_d got %h exp 1234", D); end
      checks++; if (count !== 3'd0) begin errors++; $display("FAIL single_count0 got %0d exp 0", count); end
      checks++; if (pending1 !== 1'b1) begin errors++; $display("FAIL single_pend_if got %b exp 1", pending1); end
      tick();
      checks++; if (WriteReg !== 16'h0000) begin errors++; $display("FAIL single_we_off got %h exp 0000", WriteReg); end
      checks++; if (D !== 16'h1234) begin errors++; $display("FAIL single_d_hold got %h exp 1234", D); end
      checks++; if (pending1 !== 1'b0) begin errors++; $display("FAIL single_pend_done got %b exp 0", pending1); end
      checks++; if (rf_data1 !== 16'h1234) begin errors++; $display("FAIL single_commit got %h exp 1234", rf_data1); end
   endtask

   task automatic test_full;
      rf_busy = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         wb_valid = 1'b1; wb_reg = 4'(i); wb_data = 16'h1000 + 16'(i);
         tick();
      end
      #1;
      checks++; if (count !== 3'd4) begin errors++; $display("FAIL full_count got %0d exp 4", count); end
      checks++; if (wb_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %b exp 0", wb_ready); end
      checks++; if (WriteReg !== 16'h0000) begin errors++; $display("FAIL full_busy_we got %h exp 0000", WriteReg); end
      wb_reg = 4'd9; wb_data = 16'h9999;
      tick();
      checks++; if (count !== 3'd4) begin errors++; $display("FAIL full_reject got %0d exp 4", count); end
      wb_valid = 1'b0; rf_busy = 1'b0;
      tick();
      checks++; if (WriteReg !== 16'h0002 || D !== 16'h1001) begin errors++; $display("FAIL full_drain1 got %h/%h exp 0002/1001", WriteReg, D); end
      checks++; if (wb_ready !== 1'b1 || count !== 3'd3) begin errors++; $display("FAIL full_ready_rise got %b/%0d exp 1/3", wb_ready, count); end
      tick();
      checks++; if (WriteReg !== 16'h0004 || D !== 16'h1002) begin errors++; $display("FAIL full_drain2 got %h/%h exp 0004/1002", WriteReg, D); end
      tick();
      checks++; if (WriteReg !== 16'h0008 || D !== 16'h1003) begin errors++; $display("FAIL full_drain3 got %h/%h exp 0008/1003", WriteReg, D); end
      tick();
      checks++; if (WriteReg !== 16'h0010 || D !== 16'h1004) begin errors++; $display("FAIL full_drain4 got %h/%h exp 0010/1004", WriteReg, D); end
      checks++; if (count !== 3'd0) begin errors++; $display("FAIL full_empty got %0d exp 0", count); end
      tick();
      checks++; if (WriteReg !== 16'h0000) begin errors++; $display("FAIL full_no_r9 got %h exp 0000", WriteReg); end
   endtask

   task automatic test_same_reg;
      rd_reg1 = 4'd5;
      wb_valid = 1'b1; wb_reg = 4'd5; wb_data = 16'hAAAA;
      tick();
      wb_data = 16'h5555;
      tick();
      wb_valid = 1'b0;
      #1;
`ifdef WBQ_BYPASS_EN
      exp = 16'h5555;
`else
      exp = 16'h0000;
`endif
      checks++; if (WriteReg !== 16'h0020 || D !== 16'hAAAA) begin errors++; $display("FAIL same_first got %h/%h exp 0020/aaaa", WriteReg, D); end
      checks++; if (pending1 !== 1'b1) begin errors++; $display("FAIL same_pend_a got %b exp 1", pending1); end
      checks++; if (rd_data1 !== exp) begin errors++; $display("FAIL same_rd_a got %h exp %h", rd_data1, exp); end
      tick();
`ifdef WBQ_BYPASS_EN
      exp = 16'h5555;
`else
      exp = 16'hAAAA;
`endif
      checks++; if (WriteReg !== 16'h0020 || D !== 16'h5555) begin errors++; $display("FAIL same_second got %h/%h exp 0020/5555", WriteReg, D); end
      checks++; if (pending1 !== 1'b1) begin errors++; $display("FAIL same_pend_b got %b exp 1", pending1); end
      checks++; if (rd_data1 !== exp) begin errors++; $display("FAIL same_rd_b got %h exp %h", rd_data1, exp); end
      tick();
      checks++; if (pending1 !== 1'b0) begin errors++; $display("FAIL same_pend_c got %b exp 0", pending1); end
      checks++; if (rd_data1 !== 16'h5555) begin errors++; $display("FAIL same_rd_c got %h exp 5555", rd_data1); end
   endtask

   task automatic test_r0;
      rd_reg1 = 4'd0;
      wb_valid = 1'b1; wb_reg = 4'd0; wb_data = 16'hFFFF;
      #1;
      checks++; if (wb_ready !== 1'b1) begin errors++; $display("FAIL r0_ready got %b exp 1", wb_ready); end
      tick();
      wb_valid = 1'b0;
      #1;
      checks++; if (count !== 3'd0) begin errors++; $display("FAIL r0_count got %0d exp 0", count); end
      checks++; if (pending1 !== 1'b0) begin errors++; $display("FAIL r0_pend got %b exp 0", pending1); end
      seen = '0;
      for (int i = 0; i < 3; i++) begin
         tick();
         seen |= WriteReg;
      end
      checks++; if (seen !== 16'h0000) begin errors++; $display("FAIL r0_we got %h exp 0000", seen); end
   endtask

   task automatic test_reset_mid;
      rf_busy = 1'b1;
      wb_valid = 1'b1; wb_reg = 4'd6; wb_data = 16'h6666;
      tick();
      wb_reg = 4'd7; wb_data = 16'h7777;
      tick();
      wb_valid = 1'b0;
      #1;
      checks++; if (count !== 3'd2) begin errors++; $display("FAIL rmid_fill got %0d exp 2", count); end
      rst = 1'b1;
      tick();
      checks++; if (count !== 3'd0 || WriteReg !== 16'h0000) begin errors++; $display("FAIL rmid_clear got %0d/%h exp 0/0000", count, WriteReg); end
      rst = 1'b0; rf_busy = 1'b0;
      seen = '0;
      for (int i = 0; i < 4; i++) begin
         tick();
         seen |= WriteReg;
      end
      checks++; if (seen !== 16'h0000) begin errors++; $display("FAIL rmid_we got %h exp 0000", seen); end
      checks++; if (regs[6] !== 16'h0000 || regs[7] !== 16'h0000) begin errors++; $display("FAIL rmid_regs got %h/%h exp 0000/0000", regs[6], regs[7]); end
   endtask

   task automatic test_pending_r7;
      rf_busy = 1'b1;
      wb_valid = 1'b1; wb_reg = 4'd7; wb_data = 16'h7070;
      tick();
      wb_valid = 1'b0;
      rd_reg2 = 4'd7; rf2_ovr = 1'b1; rf2_val = 16'h0BAD;
      #1;
`ifdef WBQ_BYPASS_EN
      exp = 16'h7070;
`else
      exp = 16'h0BAD;
`endif
      checks++; if (pending2 !== 1'b1) begin errors++; $display("FAIL r7_pend got %b exp 1", pending2); end
      checks++; if (rd_data2 !== exp) begin errors++; $display("FAIL r7_rd got %h exp %h", rd_data2, exp); end
      rf_busy = 1'b0;
      tick();
      tick();
      rf2_ovr = 1'b0;
      #1;
      checks++; if (pending2 !== 1'b0 || rd_data2 !== 16'h7070) begin errors++; $display("FAIL r7_done got %b/%h exp 0/7070", pending2, rd_data2); end
   endtask

   initial begin
      for (int i = 0; i < 16; i++) regs[i] = '0;
      test_reset();
      test_single();
      test_full();
      test_same_reg();
      test_r0();
      test_reset_mid();
      test_pending_r7();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
